// File: rtl/seq_divider_pkg.sv
// Shared definitions for the step-through restoring divider.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    DIV   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Quotient reported for a zero divisor; sliced down to the operand width.
  localparam logic [63:0] DZ_QUOT = '1;

endpackage

// File: rtl/seq_divider_hex_decoder.sv
// Hex nibble to active-low seven-segment pattern, seg[0]=a .. seg[6]=g.
module hex_decoder (
  input  logic [3:0] hex,
  output logic [0:6] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b1100000;
      4'hc: seg = 7'b0110001;
      4'hd: seg = 7'b1000010;
      4'he: seg = 7'b0110000;
      4'hf: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Step-through unsigned restoring divider; one KEY1 edge per FSM step.
//
// state | meaning
// GET_A | next edge captures dividend from SW
// GET_B | next edge captures divisor (zero divisor finishes at once)
// DIV   | one restoring iteration per edge, WIDTH edges in total
// DONE  | results held; next edge captures a new dividend
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             KEY1,
  input  logic             KEY0,
  input  logic [WIDTH-1:0] SW,
  output logic [0:6]       HEX0,
  output logic [0:6]       HEX1,
  output logic [0:6]       HEX2,
  output logic [0:6]       HEX3,
  output logic [0:6]       HEX4,
  output logic [0:6]       HEX5,
  output logic             LEDR0,
  output logic             LEDR1,
  output logic             LEDR2
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [WIDTH:0]   t;
  logic             t_ge_b;
  logic             r_msb_unused;

  assign t            = {r[WIDTH-1:0], q[WIDTH-1]};
  assign t_ge_b       = (t >= {1'b0, b});
  assign r_msb_unused = r[WIDTH];

  always_ff @(posedge KEY1 or negedge KEY0) begin
    if (!KEY0) begin
      state <= GET_A;
      a     <= '0;
      b     <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        GET_A, DONE: begin
          a     <= SW;
          q     <= SW;
          r     <= '0;
          dz    <= 1'b0;
          state <= GET_B;
        end
        GET_B: begin
          b <= SW;
          if (SW == '0) begin
            q     <= DZ_QUOT[WIDTH-1:0];
            r     <= {1'b0, a};
            dz    <= 1'b1;
            state <= DONE;
          end else begin
            r     <= '0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          r   <= t_ge_b ? (t - {1'b0, b}) : t;
          q   <= {q[WIDTH-2:0], t_ge_b};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= DONE;
        end
        default: state <= GET_A;
      endcase
    end
  end

  logic [7:0] disp_b;
  logic [7:0] disp_mid;
  logic [7:0] disp_q;

  // In DONE the dividend digits are reused to show the remainder.
  assign disp_b   = 8'(b);
  assign disp_mid = (state == DONE) ? 8'(r[WIDTH-1:0]) : 8'(a);
  assign disp_q   = 8'(q);

  assign LEDR0 = (state == DONE);
  assign LEDR1 = dz;
  assign LEDR2 = (state == DIV);

  hex_decoder u_hex0 (.hex(disp_b[3:0]),   .seg(HEX0));
  hex_decoder u_hex1 (.hex(disp_b[7:4]),   .seg(HEX1));
  hex_decoder u_hex2 (.hex(disp_mid[3:0]), .seg(HEX2));
  hex_decoder u_hex3 (.hex(disp_mid[7:4]), .seg(HEX3));
  hex_decoder u_hex4 (.hex(disp_q[3:0]),   .seg(HEX4));
  hex_decoder u_hex5 (.hex(disp_q[7:4]),   .seg(HEX5));

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: checks HEX/LED outputs against hand-computed results.
module tb_seq_divider;

  logic       KEY1;
  logic       KEY0;
  logic [7:0] SW;
  logic [0:6] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       LEDR0, LEDR1, LEDR2;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8)) dut (
    .KEY1 (KEY1),
    .KEY0 (KEY0),
    .SW   (SW),
    .HEX0 (HEX0),
    .HEX1 (HEX1),
    .HEX2 (HEX2),
    .HEX3 (HEX3),
    .HEX4 (HEX4),
    .HEX5 (HEX5),
    .LEDR0(LEDR0),
    .LEDR1(LEDR1),
    .LEDR2(LEDR2)
  );

  function automatic logic [0:6] seg(input logic [3:0] n);
    logic [0:6] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b1100000;
      4'hc: s = 7'b0110001;
      4'hd: s = 7'b1000010;
      4'he: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  function automatic logic [13:0] seg2(input logic [7:0] v);
    return {seg(v[7:4]), seg(v[3:0])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // One KEY1 rising edge with SW set up beforehand; returns mid-low-phase.
  task automatic pulse(input logic [7:0] sw);
    SW = sw;
    #5 KEY1 = 1'b1;
    #5 KEY1 = 1'b0;
  endtask

  task automatic chk_leds(input string tag, input logic done, input logic dz, input logic busy);
    chk({tag, "_leds"}, {29'd0, LEDR2, LEDR1, LEDR0}, {29'd0, busy, dz, done});
  endtask

  task automatic chk_hex(input string tag, input logic [7:0] q, input logic [7:0] mid,
                         input logic [7:0] b);
    chk({tag, "_q"},   {18'd0, HEX5, HEX4}, {18'd0, seg2(q)});
    chk({tag, "_mid"}, {18'd0, HEX3, HEX2}, {18'd0, seg2(mid)});
    chk({tag, "_b"},   {18'd0, HEX1, HEX0}, {18'd0, seg2(b)});
  endtask

  task automatic divide(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] qv, input logic [7:0] rv);
    pulse(av);
    chk_leds({tag, "_geta"}, 1'b0, 1'b0, 1'b0);
    chk({tag, "_a"}, {18'd0, HEX3, HEX2}, {18'd0, seg2(av)});
    pulse(bv);
    for (int i = 1; i <= 8; i++) begin
      pulse(8'h00);
      if (i < 8) chk_leds({tag, "_step"}, 1'b0, 1'b0, 1'b1);
    end
    chk_leds({tag, "_done"}, 1'b1, 1'b0, 1'b0);
    chk_hex({tag, "_res"}, qv, rv, bv);
  endtask

  initial begin
    KEY1 = 1'b0;
    KEY0 = 1'b0;
    SW   = 8'h00;
    #3;
    chk_leds("reset", 1'b0, 1'b0, 1'b0);
    chk_hex("reset", 8'h00, 8'h00, 8'h00);
    KEY0 = 1'b1;
    #2;

    // 200/7 with step-by-step busy checks
    pulse(8'hc8);
    chk_leds("d200_geta", 1'b0, 1'b0, 1'b0);
    chk_hex("d200_geta", 8'hc8, 8'hc8, 8'h00);
    pulse(8'h07);
    chk_leds("d200_getb", 1'b0, 1'b0, 1'b1);
    chk_hex("d200_getb", 8'hc8, 8'hc8, 8'h07);
    for (int i = 1; i <= 8; i++) begin
      pulse(8'h00);
      if (i < 8) chk_leds("d200_step", 1'b0, 1'b0, 1'b1);
    end
    chk_leds("d200_done", 1'b1, 1'b0, 1'b0);
    chk_hex("d200_done", 8'h1c, 8'h04, 8'h07);

    // back-to-back from DONE
    pulse(8'h64);
    chk_leds("b2b_geta", 1'b0, 1'b0, 1'b0);
    chk_hex("b2b_geta", 8'h64, 8'h64, 8'h07);
    pulse(8'h0a);
    for (int i = 1; i <= 8; i++) pulse(8'h00);
    chk_leds("b2b_done", 1'b1, 1'b0, 1'b0);
    chk_hex("b2b_done", 8'h0a, 8'h00, 8'h0a);

    divide("d255", 8'hff, 8'h01, 8'hff, 8'h00);
    divide("d5", 8'h05, 8'h0a, 8'h00, 8'h05);
    divide("d250", 8'hfa, 8'h0b, 8'h16, 8'h08);

    // divide by zero
    pulse(8'h2a);
    pulse(8'h00);
    chk_leds("dz_done", 1'b1, 1'b1, 1'b0);
    chk_hex("dz_done", 8'hff, 8'h2a, 8'h00);
    pulse(8'h10);
    chk_leds("dz_clear", 1'b0, 1'b0, 1'b0);
    chk_hex("dz_clear", 8'h10, 8'h10, 8'h00);

    // reset mid-division of 200/7 after step 4
    #1 KEY0 = 1'b0;
    #1 KEY0 = 1'b1;
    pulse(8'hc8);
    pulse(8'h07);
    for (int i = 1; i <= 4; i++) pulse(8'h00);
    chk_leds("mid_busy", 1'b0, 1'b0, 1'b1);
    #1 KEY0 = 1'b0;
    #1;
    chk_leds("mid_rst", 1'b0, 1'b0, 1'b0);
    chk_hex("mid_rst", 8'h00, 8'h00, 8'h00);
    KEY0 = 1'b1;
    #1;
    divide("d100", 8'h64, 8'h03, 8'h21, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
